// File: rtl/shared_timer_arb_if.sv
// Request/grant bundle between the requesting engines and shared_timer_arb.
// The master side drives req/len; the slave side (the arbiter) returns grant status.
interface shared_timer_arb_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] len;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic [DW-1:0]      cnt;

  modport master (output req, len, input gnt, done, busy, cnt);
  modport slave  (input req, len, output gnt, done, busy, cnt);
endinterface

// File: rtl/shared_timer_arb.sv
// Round-robin arbiter that lends one DW-bit interval counter to NREQ requesters.
// Optional macro SHARED_TIMER_ABORT_EN: a granted window aborts if its req drops.
module shared_timer_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  shared_timer_arb_if.slave bus
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic            busy_q;
  logic [DW-1:0]   cnt_q;
  logic [DW-1:0]   len_q;
  logic [IW-1:0]   last_q;

  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] win_oh;
  logic [DW-1:0]   sel_len;

  // Search starts one past the previous winner so a held request cannot starve others.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      int idx;
      idx = (int'(last_q) + i) % NREQ;
      if (!win_vld && bus.req[idx]) begin
        win_vld = 1'b1;
        win_idx = IW'(idx);
      end
    end
  end

  assign win_oh  = NREQ'(1) << win_idx;
  assign sel_len = bus.len[win_idx*DW +: DW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      last_q  <= IW'(NREQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= '0;
          if (win_vld) begin
            state_q <= RUN;
            gnt_q   <= win_oh;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            last_q  <= win_idx;
            len_q   <= sel_len;
            // Windows of length 0 or 1 finish in their first grant cycle.
            if (sel_len <= DW'(1)) done_q <= win_oh;
          end
        end
        RUN: begin
          if (done_q != '0) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end
`ifdef SHARED_TIMER_ABORT_EN
          else if ((bus.req & gnt_q) == '0) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end
`endif
          else begin
            cnt_q <= cnt_q + DW'(1);
            // Next cycle is the final one when cnt+1 == len_q-1; widened to avoid wrap.
            if ((DW+1)'(cnt_q) + (DW+1)'(2) == (DW+1)'(len_q)) done_q <= gnt_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.cnt  = cnt_q;
endmodule
